// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch run/pause/clear controller.
package stopwatch_pkg;

    // Controller state: IDLE holds the chain loaded, RUN counts down,
    // PAUSE freezes the tick phase, DONE parks the chain at zero.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    // One count tick per second from a 100 MHz board clock.
    localparam int DIV_DEFAULT      = 100_000_000;
    localparam int SYNC_LEN_DEFAULT = 2;

    // States in which the prescaler is parked at zero and the lap hold is dropped.
    function automatic logic is_parked(input state_e s);
        return (s == IDLE) || (s == DONE);
    endfunction

    // States in which the lap button is honoured.
    function automatic logic is_active(input state_e s);
        return (s == RUN) || (s == PAUSE);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button and counter-chain signals of the stopwatch controller.
// The board/testbench side is the master, the controller is the slave.
interface stopwatch_ctrl_if;
    logic start_btn;
    logic clear_btn;
    logic lap_btn;
    logic zero_in;
    logic cnt_ce;
    logic cnt_load;
    logic cnt_stop;
    logic running;
    logic done;
    logic lap_freeze;

    modport master (
        output start_btn, clear_btn, lap_btn, zero_in,
        input  cnt_ce, cnt_load, cnt_stop, running, done, lap_freeze
    );

    modport slave (
        input  start_btn, clear_btn, lap_btn, zero_in,
        output cnt_ce, cnt_load, cnt_stop, running, done, lap_freeze
    );
endinterface

// File: rtl/stopwatch_ctrl_btn_edge.sv
// Raw push-button to single-cycle press pulse: SYNC_LEN-flop synchronizer
// followed by a rising-edge detector. A held button yields one pulse.
module btn_edge
    import stopwatch_pkg::*;
#(
    parameter int SYNC_LEN = SYNC_LEN_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic pulse
);

    logic [SYNC_LEN-1:0] sync_q;
    logic                prev_q;

    // Shift the raw button through the synchronizer and remember the last synced level.
    // NOTE: sequential state is written with '<=' only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_LEN-2:0], btn};
            prev_q <= sync_q[SYNC_LEN-1];
        end
    end

    assign pulse = sync_q[SYNC_LEN-1] & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear controller for the countdown digit chain.
// Cleans the buttons, divides clk into a one-cycle count enable every DIV
// cycles while running, loads/stops the digit counters and flags done when
// the chain reaches all-zero on a terminal tick.
// Optional feature: define STOPWATCH_LAP_EN to enable the lap-freeze toggle;
// without it lap_btn is ignored and lap_freeze is tied low.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DIV      = DIV_DEFAULT,
    parameter int SYNC_LEN = SYNC_LEN_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    stopwatch_ctrl_if.slave  sw
);

    localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] TERM = PW'(DIV - 1);

    logic start_pulse;
    logic clear_pulse;
    logic lap_pulse;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick;
    logic          ce_d;
    logic          cnt_ce_q;
    logic          cnt_load_q;
    logic          cnt_stop_q;
    logic          running_q;
    logic          done_q;
    logic          lap_freeze_q;

    btn_edge #(.SYNC_LEN(SYNC_LEN)) u_start_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (sw.start_btn),
        .pulse   (start_pulse)
    );

    btn_edge #(.SYNC_LEN(SYNC_LEN)) u_clear_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (sw.clear_btn),
        .pulse   (clear_pulse)
    );

`ifdef STOPWATCH_LAP_EN
    btn_edge #(.SYNC_LEN(SYNC_LEN)) u_lap_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (sw.lap_btn),
        .pulse   (lap_pulse)
    );
`else
    logic lap_btn_unused;
    assign lap_btn_unused = sw.lap_btn;
    assign lap_pulse      = 1'b0;
`endif

    // Terminal prescaler count while running: the cycle a count tick is due.
    assign tick = (state_q == RUN) && (presc_q == TERM);

    // Next state, prescaler and count enable; clear overrides everything,
    // a zero chain on a terminal tick beats a simultaneous pause request.
    // NOTE: every always_comb output is given a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_pulse) state_d = RUN;
            RUN: begin
                if (tick && sw.zero_in) state_d = DONE;
                else if (start_pulse)   state_d = PAUSE;
            end
            PAUSE:   if (start_pulse) state_d = RUN;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (clear_pulse) state_d = IDLE;

        presc_d = presc_q;
        if (is_parked(state_d)) begin
            presc_d = '0;
        end else if (state_q == RUN) begin
            presc_d = (presc_q == TERM) ? '0 : presc_q + 1'b1;
        end

        ce_d = tick && !sw.zero_in && !clear_pulse;
    end

    // State register, prescaler and registered Moore decodes of the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            cnt_ce_q   <= 1'b0;
            cnt_load_q <= 1'b1;
            cnt_stop_q <= 1'b0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            cnt_ce_q   <= ce_d;
            cnt_load_q <= (state_d == IDLE);
            cnt_stop_q <= (state_d == DONE);
            running_q  <= (state_d == RUN);
            done_q     <= (state_d == DONE);
        end
    end

`ifdef STOPWATCH_LAP_EN
    // Lap hold: toggled by a lap press while counting or paused, dropped in IDLE/DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lap_freeze_q <= 1'b0;
        end else if (is_parked(state_d)) begin
            lap_freeze_q <= 1'b0;
        end else if (lap_pulse && is_active(state_q)) begin
            lap_freeze_q <= ~lap_freeze_q;
        end
    end
`else
    assign lap_freeze_q = 1'b0;
`endif

    assign sw.cnt_ce     = cnt_ce_q;
    assign sw.cnt_load   = cnt_load_q;
    assign sw.cnt_stop   = cnt_stop_q;
    assign sw.running    = running_q;
    assign sw.done       = done_q;
    assign sw.lap_freeze = lap_freeze_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl at DIV=4, SYNC_LEN=2.
// A behavioural model tracks mode and tick phase from the raw button history;
// a negedge process compares every output each cycle, and directed sections
// pin timing with hand-computed literals.
module tb_stopwatch_ctrl;

    localparam int DIV = 4;

    typedef enum int {MD_IDLE, MD_RUN, MD_PAUSE, MD_DONE} md_e;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_fail;
    int   cyc;

    stopwatch_ctrl_if sw_if ();

    stopwatch_ctrl #(.DIV(DIV), .SYNC_LEN(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sw      (sw_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    md_e      m_mode;
    int       m_phase;
    bit       m_ce;
    bit       m_lap;
    bit [2:0] h_start, h_clear, h_lap;   // [0]=raw at previous edge, [1]=two edges ago, ...

    always @(posedge clk or negedge reset_n) begin : model
        md_e mode;
        int  phase;
        bit  ce, lap, st_p, cl_p, lp_p, wrap;
        if (!reset_n) begin
            m_mode  <= MD_IDLE;
            m_phase <= 0;
            m_ce    <= 1'b0;
            m_lap   <= 1'b0;
            h_start <= '0;
            h_clear <= '0;
            h_lap   <= '0;
        end else begin
            st_p  = h_start[1] && !h_start[2];
            cl_p  = h_clear[1] && !h_clear[2];
            lp_p  = h_lap[1]   && !h_lap[2];
            mode  = m_mode;
            phase = m_phase;
            lap   = m_lap;
            ce    = 1'b0;
            if (cl_p) begin
                mode  = MD_IDLE;
                phase = 0;
                lap   = 1'b0;
            end else begin
                case (mode)
                    MD_IDLE: if (st_p) begin mode = MD_RUN; phase = 0; end
                    MD_RUN: begin
                        wrap  = (phase == DIV - 1);
                        phase = (phase + 1) % DIV;
                        if (wrap && sw_if.zero_in) begin
                            mode  = MD_DONE;
                            phase = 0;
                            lap   = 1'b0;
                        end else begin
                            ce = wrap;
                            if (st_p) mode = MD_PAUSE;
                            if (lp_p) lap = !lap;
                        end
                    end
                    MD_PAUSE: begin
                        if (st_p) mode = MD_RUN;
                        if (lp_p) lap = !lap;
                    end
                    default: ;
                endcase
            end
            m_mode  <= mode;
            m_phase <= phase;
            m_ce    <= ce;
            m_lap   <= lap;
            h_start <= {h_start[1:0], sw_if.start_btn};
            h_clear <= {h_clear[1:0], sw_if.clear_btn};
            h_lap   <= {h_lap[1:0],   sw_if.lap_btn};
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        bit exp_lap;
`ifdef STOPWATCH_LAP_EN
        exp_lap = m_lap;
`else
        exp_lap = 1'b0;
`endif
        check("cyc_cnt_ce",     sw_if.cnt_ce,     m_ce);
        check("cyc_cnt_load",   sw_if.cnt_load,   m_mode == MD_IDLE);
        check("cyc_cnt_stop",   sw_if.cnt_stop,   m_mode == MD_DONE);
        check("cyc_running",    sw_if.running,    m_mode == MD_RUN);
        check("cyc_done",       sw_if.done,       m_mode == MD_DONE);
        check("cyc_lap_freeze", sw_if.lap_freeze, exp_lap);
    end

    // ---------------- event monitor for directed timing checks ----------------
    int ce_q[$];
    int run_rise_cyc;
    int run_rises;
    bit prev_run;

    always @(negedge clk) begin
        if (sw_if.cnt_ce) ce_q.push_back(cyc);
        if (sw_if.running && !prev_run) begin
            run_rise_cyc <= cyc;
            run_rises    <= run_rises + 1;
        end
        prev_run <= sw_if.running;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_start();
        sw_if.start_btn = 1'b1;
        step(1);
        sw_if.start_btn = 1'b0;
    endtask

    task automatic do_clear();
        sw_if.clear_btn = 1'b1;
        step(1);
        sw_if.clear_btn = 1'b0;
        step(3);
    endtask

    function automatic int ce_stamp(input int idx);
        return (idx < ce_q.size()) ? ce_q[idx] : -1000;
    endfunction

    // ---------------- directed stimulus ----------------
    initial begin : stim
        int base_ce;
        int base_r;
        n_cmp           = 0;
        n_fail          = 0;
        cyc             = 0;
        run_rise_cyc    = 0;
        run_rises       = 0;
        prev_run        = 1'b0;
        reset_n         = 1'b0;
        sw_if.start_btn = 1'b0;
        sw_if.clear_btn = 1'b0;
        sw_if.lap_btn   = 1'b0;
        sw_if.zero_in   = 1'b0;
        step(3);
        check("rst_cnt_load", sw_if.cnt_load, 1);
        check("rst_cnt_ce",   sw_if.cnt_ce,   0);
        check("rst_running",  sw_if.running,  0);
        check("rst_done",     sw_if.done,     0);
        reset_n = 1'b1;
        step(2);
        check("idle_cnt_load",   sw_if.cnt_load,   1);
        check("idle_cnt_stop",   sw_if.cnt_stop,   0);
        check("idle_lap_freeze", sw_if.lap_freeze, 0);

        // Held start: one RUN entry, ticks every 4 cycles, first 4 cycles after RUN.
        base_ce = ce_q.size();
        base_r  = run_rises;
        sw_if.start_btn = 1'b1;
        step(10);
        sw_if.start_btn = 1'b0;
        step(6);
        check("held_run_entries", run_rises - base_r, 1);
        check("held_ce_count",    ce_q.size() - base_ce, 3);
        check("held_first_ce",    ce_stamp(base_ce) - run_rise_cyc, 4);
        check("held_ce_period",   ce_stamp(base_ce + 1) - ce_stamp(base_ce), 4);

        // Pause after two prescaler cycles, idle 20 cycles, resume.
        do_clear();
        base_ce = ce_q.size();
        press_start();
        step(1);
        press_start();
        step(20);
        check("pause_no_ce",    ce_q.size() - base_ce, 0);
        check("pause_running",  sw_if.running,  0);
        check("pause_cnt_load", sw_if.cnt_load, 0);
        base_ce = ce_q.size();
        press_start();
        step(6);
        check("resume_ce_count", ce_q.size() - base_ce, 1);
        check("resume_first_ce", ce_stamp(base_ce) - run_rise_cyc, 2);

        // Chain at zero on the terminal tick: DONE, no count enable, start ignored.
        do_clear();
        sw_if.zero_in = 1'b1;
        base_ce = ce_q.size();
        press_start();
        step(10);
        check("zero_no_ce",    ce_q.size() - base_ce, 0);
        check("zero_done",     sw_if.done,     1);
        check("zero_cnt_stop", sw_if.cnt_stop, 1);
        check("zero_running",  sw_if.running,  0);
        press_start();
        step(4);
        check("done_start_ignored", sw_if.done,    1);
        check("done_not_running",   sw_if.running, 0);
        sw_if.zero_in = 1'b0;
        do_clear();
        check("done_clear_load", sw_if.cnt_load, 1);
        check("done_clear_done", sw_if.done,     0);

        // Start and clear together from PAUSE: clear wins, prescaler restarts at 0.
        press_start();
        step(1);
        press_start();
        step(3);
        check("pause_reached", sw_if.cnt_load + 2 * sw_if.running, 0);
        sw_if.start_btn = 1'b1;
        sw_if.clear_btn = 1'b1;
        step(1);
        sw_if.start_btn = 1'b0;
        sw_if.clear_btn = 1'b0;
        step(3);
        check("both_cnt_load", sw_if.cnt_load, 1);
        check("both_running",  sw_if.running,  0);
        base_ce = ce_q.size();
        press_start();
        step(8);
        check("both_presc_zero", ce_stamp(base_ce) - run_rise_cyc, 4);

        // Start coinciding with the terminal tick: tick still issued, then PAUSE.
        do_clear();
        base_ce = ce_q.size();
        press_start();
        step(3);
        press_start();
        step(4);
        check("term_start_ce",      ce_q.size() - base_ce, 1);
        check("term_start_ce_time", ce_stamp(base_ce) - run_rise_cyc, 4);
        check("term_start_paused",  sw_if.running,  0);
        check("term_start_no_load", sw_if.cnt_load, 0);

        // Lap press while running: counting unaffected, clear drops the hold.
        do_clear();
        press_start();
        step(4);
        sw_if.lap_btn = 1'b1;
        step(1);
        sw_if.lap_btn = 1'b0;
        step(3);
`ifdef STOPWATCH_LAP_EN
        check("lap_freeze_set", sw_if.lap_freeze, 1);
`else
        check("lap_tied_low",   sw_if.lap_freeze, 0);
`endif
        base_ce = ce_q.size();
        step(8);
        check("lap_ce_continues", ce_q.size() - base_ce, 2);
        do_clear();
        check("lap_clear", sw_if.lap_freeze, 0);

        // Asynchronous reset mid-count.
        press_start();
        step(5);
        reset_n = 1'b0;
        #1;
        check("arst_cnt_load", sw_if.cnt_load, 1);
        check("arst_running",  sw_if.running,  0);
        check("arst_cnt_ce",   sw_if.cnt_ce,   0);
        check("arst_lap",      sw_if.lap_freeze, 0);
        step(2);
        reset_n = 1'b1;
        step(2);
        check("arst_release_load", sw_if.cnt_load, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
